// File: rtl/interpolate_iq.sv
// I/Q upsampler by R = 2^L: zero-order hold by default, linear interpolation
// between consecutive held samples when INTERPOLATE_IQ_LINEAR_EN is defined.
//
//   state | meaning
//   IDLE  | no held sample, waiting for an input
//   EMIT  | emitting outputs phase 0..R-1 for the held sample
module interpolate_iq #(
    parameter int DATA_WIDTH        = 16,
    parameter int MAX_RATE_LOG2     = 8,
    parameter int DEFAULT_RATE_LOG2 = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               clear,
    input  logic                               rate_stb,
    input  logic [$clog2(MAX_RATE_LOG2+1)-1:0] rate_log2,
    input  logic                               in_tvalid,
    input  logic                               in_tlast,
    output logic                               in_tready,
    input  logic [DATA_WIDTH-1:0]              in_itdata,
    input  logic [DATA_WIDTH-1:0]              in_qtdata,
    output logic                               out_tvalid,
    output logic                               out_tlast,
    input  logic                               out_tready,
    output logic [DATA_WIDTH-1:0]              out_itdata,
    output logic [DATA_WIDTH-1:0]              out_qtdata
);
    localparam int LW = $clog2(MAX_RATE_LOG2 + 1);
    localparam int PW = MAX_RATE_LOG2 + 1;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         phase_q, phase_d;
    logic [LW-1:0]         l_q, l_d;
    logic [DATA_WIDTH-1:0] hold_i_q, hold_i_d;
    logic [DATA_WIDTH-1:0] hold_q_q, hold_q_d;
    logic                  last_q, last_d;

    logic [PW-1:0] last_phase;
    logic [LW-1:0] rate_clamped;
    logic          at_last;
    logic          out_hs;
    logic          in_acc;
    logic          flush;

    assign last_phase   = (PW'(1) << l_q) - PW'(1);
    assign rate_clamped = (rate_log2 > LW'(MAX_RATE_LOG2)) ? LW'(MAX_RATE_LOG2) : rate_log2;
    assign at_last      = (phase_q == last_phase);
    assign flush        = clear | rate_stb;

    assign out_tvalid = (state_q == EMIT);
    assign out_tlast  = out_tvalid & last_q & at_last;
    assign out_hs     = out_tvalid & out_tready;

    // reset gates the ready so nothing is taken while the block is held in reset
    assign in_tready = reset & ~flush & ((state_q == IDLE) | (at_last & out_hs));
    assign in_acc    = in_tvalid & in_tready;

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        l_d      = l_q;
        hold_i_d = hold_i_q;
        hold_q_d = hold_q_q;
        last_d   = last_q;
        if (flush) begin
            state_d  = IDLE;
            phase_d  = '0;
            hold_i_d = '0;
            hold_q_d = '0;
            last_d   = 1'b0;
            if (!clear) begin
                l_d = rate_clamped;
            end
        end else if (in_acc) begin
            state_d  = EMIT;
            phase_d  = '0;
            hold_i_d = in_itdata;
            hold_q_d = in_qtdata;
            last_d   = in_tlast;
        end else if (out_hs) begin
            if (at_last) begin
                state_d = IDLE;
                phase_d = '0;
            end else begin
                phase_d = phase_q + PW'(1);
            end
        end
    end

`ifdef INTERPOLATE_IQ_LINEAR_EN
    localparam int AW = DATA_WIDTH + 1 + MAX_RATE_LOG2;

    // acc holds prev*R + k*(cur-prev); the output is acc >>> L (floor division)
    logic signed [AW-1:0]         acc_i_q, acc_i_d;
    logic signed [AW-1:0]         acc_q_q, acc_q_d;
    logic        [DATA_WIDTH:0]   dlt_i_q, dlt_i_d;
    logic        [DATA_WIDTH:0]   dlt_q_q, dlt_q_d;

    always_comb begin
        acc_i_d = acc_i_q;
        acc_q_d = acc_q_q;
        dlt_i_d = dlt_i_q;
        dlt_q_d = dlt_q_q;
        if (flush) begin
            acc_i_d = '0;
            acc_q_d = '0;
            dlt_i_d = '0;
            dlt_q_d = '0;
        end else if (in_acc) begin
            dlt_i_d = {in_itdata[DATA_WIDTH-1], in_itdata} - {hold_i_q[DATA_WIDTH-1], hold_i_q};
            dlt_q_d = {in_qtdata[DATA_WIDTH-1], in_qtdata} - {hold_q_q[DATA_WIDTH-1], hold_q_q};
            acc_i_d = $signed({{(AW-DATA_WIDTH){hold_i_q[DATA_WIDTH-1]}}, hold_i_q}) <<< l_q;
            acc_q_d = $signed({{(AW-DATA_WIDTH){hold_q_q[DATA_WIDTH-1]}}, hold_q_q}) <<< l_q;
        end else if (out_hs && !at_last) begin
            acc_i_d = acc_i_q + $signed({{(AW-DATA_WIDTH-1){dlt_i_q[DATA_WIDTH]}}, dlt_i_q});
            acc_q_d = acc_q_q + $signed({{(AW-DATA_WIDTH-1){dlt_q_q[DATA_WIDTH]}}, dlt_q_q});
        end
    end

    assign out_itdata = DATA_WIDTH'(acc_i_q >>> l_q);
    assign out_qtdata = DATA_WIDTH'(acc_q_q >>> l_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_i_q <= '0;
            acc_q_q <= '0;
            dlt_i_q <= '0;
            dlt_q_q <= '0;
        end else begin
            acc_i_q <= acc_i_d;
            acc_q_q <= acc_q_d;
            dlt_i_q <= dlt_i_d;
            dlt_q_q <= dlt_q_d;
        end
    end
`else
    assign out_itdata = hold_i_q;
    assign out_qtdata = hold_q_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            l_q      <= LW'(DEFAULT_RATE_LOG2);
            hold_i_q <= '0;
            hold_q_q <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            l_q      <= l_d;
            hold_i_q <= hold_i_d;
            hold_q_q <= hold_q_d;
            last_q   <= last_d;
        end
    end

endmodule

// File: tb/tb_interpolate_iq.sv
// Bench for interpolate_iq: a queue-based reference model predicts every output
// burst from the arithmetic definition of hold / linear interpolation.
module tb_interpolate_iq;
    localparam int DW   = 16;
    localparam int MAXL = 8;
    localparam int DEFL = 2;
    localparam int LW   = $clog2(MAXL + 1);
`ifdef INTERPOLATE_IQ_LINEAR_EN
    localparam bit LIN = 1'b1;
`else
    localparam bit LIN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          clear = 1'b0;
    logic          rate_stb = 1'b0;
    logic [LW-1:0] rate_log2 = '0;
    logic          in_tvalid = 1'b0;
    logic          in_tlast = 1'b0;
    logic          in_tready;
    logic [DW-1:0] in_itdata = '0;
    logic [DW-1:0] in_qtdata = '0;
    logic          out_tvalid;
    logic          out_tlast;
    logic          out_tready = 1'b0;
    logic [DW-1:0] out_itdata;
    logic [DW-1:0] out_qtdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    interpolate_iq #(.DATA_WIDTH(DW), .MAX_RATE_LOG2(MAXL), .DEFAULT_RATE_LOG2(DEFL)) dut (
        .clk(clk), .reset(reset), .clear(clear), .rate_stb(rate_stb), .rate_log2(rate_log2),
        .in_tvalid(in_tvalid), .in_tlast(in_tlast), .in_tready(in_tready),
        .in_itdata(in_itdata), .in_qtdata(in_qtdata),
        .out_tvalid(out_tvalid), .out_tlast(out_tlast), .out_tready(out_tready),
        .out_itdata(out_itdata), .out_qtdata(out_qtdata)
    );

    typedef struct packed {
        logic        v;
        logic        last;
        logic [31:0] i;
        logic [31:0] q;
    } exp_t;

    exp_t pend[$];
    exp_t gotd[$];
    exp_t expd[$];
    int   m_prev_i = 0;
    int   m_prev_q = 0;
    int   m_l = DEFL;

    logic          s_ihs, s_ohs, s_ovalid, s_itready, s_olast;
    logic [DW-1:0] s_oi, s_oq;

    function automatic int floor_div(int num, int r);
        int m;
        m = num % r;
        if (m < 0) m += r;
        return (num - m) / r;
    endfunction

    // hold is linear interpolation with prev taken equal to cur
    task automatic model_accept(int ci, int cq, bit last);
        int   r, pi, pq;
        exp_t e;
        r  = 1 << m_l;
        pi = LIN ? m_prev_i : ci;
        pq = LIN ? m_prev_q : cq;
        for (int k = 0; k < r; k++) begin
            e.v    = 1'b1;
            e.last = last && (k == r - 1);
            e.i    = 32'(floor_div(pi * r + k * (ci - pi), r));
            e.q    = 32'(floor_div(pq * r + k * (cq - pq), r));
            pend.push_back(e);
        end
        m_prev_i = ci;
        m_prev_q = cq;
    endtask

    task automatic model_flush();
        pend.delete();
        m_prev_i = 0;
        m_prev_q = 0;
    endtask

    task automatic reset_logs();
        gotd.delete();
        expd.delete();
    endtask

    // one clock: sample at negedge, log handshakes, advance to just past posedge
    task automatic cycle();
        exp_t g, e;
        int   ci, cq;
        @(negedge clk);
        s_itready = in_tready;
        s_ovalid  = out_tvalid;
        s_olast   = out_tlast;
        s_oi      = out_itdata;
        s_oq      = out_qtdata;
        s_ihs     = in_tvalid && in_tready;
        s_ohs     = out_tvalid && out_tready;
        if (s_ohs) begin
            g.v = 1'b1; g.last = out_tlast;
            g.i = 32'($signed(out_itdata));
            g.q = 32'($signed(out_qtdata));
            e = (pend.size() > 0) ? pend.pop_front() : '0;
            gotd.push_back(g);
            expd.push_back(e);
        end
        if (clear) begin
            model_flush();
        end else if (rate_stb) begin
            model_flush();
            m_l = (int'(rate_log2) > MAXL) ? MAXL : int'(rate_log2);
        end else if (s_ihs) begin
            ci = $signed(in_itdata);
            cq = $signed(in_qtdata);
            model_accept(ci, cq, in_tlast);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_rate(int l);
        in_tvalid = 1'b0;
        rate_stb  = 1'b1;
        rate_log2 = LW'(l);
        cycle();
        rate_stb  = 1'b0;
    endtask

    task automatic send_one(int i, int q, bit last);
        in_tvalid = 1'b1;
        in_itdata = DW'(i);
        in_qtdata = DW'(q);
        in_tlast  = last;
        for (int c = 0; c < 600; c++) begin
            cycle();
            if (s_ihs) break;
        end
        in_tvalid = 1'b0;
    endtask

    task automatic drain(int budget);
        in_tvalid  = 1'b0;
        out_tready = 1'b1;
        for (int c = 0; c < budget && pend.size() > 0; c++) cycle();
        cycle();
        cycle();
    endtask

    task automatic test_reset();
        in_tvalid = 1'b1;
        in_itdata = 16'h1234;
        out_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (in_tready !== 1'b0 || out_tvalid !== 1'b0 || out_tlast !== 1'b0 ||
            out_itdata !== '0 || out_qtdata !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got rdy=%b vld=%b last=%b i=%h q=%h expected all 0",
                     in_tready, out_tvalid, out_tlast, out_itdata, out_qtdata);
        end
        in_tvalid = 1'b0;
        reset = 1'b1;
        #1;
        n_tests++;
        if (in_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready got %b expected 1", in_tready);
        end
        model_flush();
        m_l = DEFL;
        reset_logs();
        send_one(5, 6, 1);
        drain(50);
        n_tests++;
        if (gotd.size() != 4) begin
            n_fail++;
            $display("FAIL reset_default_rate got %0d outputs expected 4", gotd.size());
        end
    endtask

    task automatic test_vectors();
        reset_logs();
        out_tready = 1'b1;
        set_rate(2);
        send_one(100, -100, 1);
        drain(50);
        n_tests++;
        if (s_ovalid !== 1'b0) begin
            n_fail++;
            $display("FAIL vec_idle_after got out_tvalid=%b expected 0", s_ovalid);
        end
        send_one(0, 0, 0);
        drain(50);
        send_one(400, -400, 1);
        drain(50);
        set_rate(1);
        send_one(0, 0, 0);
        drain(50);
        send_one(-3, 3, 1);
        drain(50);
        set_rate(0);
        send_one(11, -12, 0);
        send_one(21, -22, 0);
        send_one(31, -32, 1);
        drain(50);
        n_tests++;
        if (gotd.size() != 19) begin
            n_fail++;
            $display("FAIL vec_count got %0d expected 19", gotd.size());
        end
        foreach (gotd[k]) begin
            n_tests++;
            if (gotd[k] !== expd[k]) begin
                n_fail++;
                $display("FAIL vec[%0d] got i=%0d q=%0d last=%b expected i=%0d q=%0d last=%b v=%b", k,
                         $signed(gotd[k].i), $signed(gotd[k].q), gotd[k].last,
                         $signed(expd[k].i), $signed(expd[k].q), expd[k].last, expd[k].v);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] fi, fq;
        reset_logs();
        set_rate(2);
        out_tready = 1'b1;
        send_one(7, -9, 0);
        cycle();
        out_tready = 1'b0;
        in_tvalid  = 1'b1;
        in_itdata  = DW'(11);
        in_qtdata  = DW'(13);
        in_tlast   = 1'b1;
        fi = '0;
        fq = '0;
        for (int j = 0; j < 3; j++) begin
            cycle();
            if (j == 0) begin
                fi = s_oi;
                fq = s_oq;
            end else begin
                n_tests++;
                if (s_oi !== fi || s_oq !== fq) begin
                    n_fail++;
                    $display("FAIL bp_frozen[%0d] got i=%h q=%h expected i=%h q=%h", j, s_oi, s_oq, fi, fq);
                end
            end
            n_tests++;
            if (s_ovalid !== 1'b1 || s_itready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_stall[%0d] got vld=%b rdy=%b expected vld=1 rdy=0", j, s_ovalid, s_itready);
            end
        end
        out_tready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            cycle();
            if (s_ihs) break;
        end
        drain(50);
        n_tests++;
        if (gotd.size() != 8) begin
            n_fail++;
            $display("FAIL bp_count got %0d expected 8", gotd.size());
        end
        foreach (gotd[k]) begin
            n_tests++;
            if (gotd[k] !== expd[k]) begin
                n_fail++;
                $display("FAIL bp[%0d] got i=%0d q=%0d last=%b expected i=%0d q=%0d last=%b v=%b", k,
                         $signed(gotd[k].i), $signed(gotd[k].q), gotd[k].last,
                         $signed(expd[k].i), $signed(expd[k].q), expd[k].last, expd[k].v);
            end
        end
    endtask

    task automatic test_back_to_back();
        int idx, drops;
        bit started;
        reset_logs();
        set_rate(1);
        out_tready = 1'b1;
        idx = 0;
        drops = 0;
        started = 1'b0;
        in_tvalid = 1'b1;
        for (int c = 0; c < 40 && gotd.size() < 12; c++) begin
            in_itdata = DW'($urandom);
            in_qtdata = DW'($urandom);
            in_tlast  = (idx == 5);
            cycle();
            if (s_ohs) started = 1'b1;
            if (started && !s_ovalid && gotd.size() < 12) drops++;
            if (s_ihs) idx++;
            if (idx == 6) in_tvalid = 1'b0;
        end
        drain(20);
        n_tests++;
        if (drops != 0 || gotd.size() != 12) begin
            n_fail++;
            $display("FAIL b2b_stream got drops=%0d outputs=%0d expected drops=0 outputs=12", drops, gotd.size());
        end
        foreach (gotd[k]) begin
            n_tests++;
            if (gotd[k] !== expd[k]) begin
                n_fail++;
                $display("FAIL b2b[%0d] got i=%0d q=%0d last=%b expected i=%0d q=%0d last=%b v=%b", k,
                         $signed(gotd[k].i), $signed(gotd[k].q), gotd[k].last,
                         $signed(expd[k].i), $signed(expd[k].q), expd[k].last, expd[k].v);
            end
        end
    endtask

    task automatic test_clamp();
        int nlast;
        reset_logs();
        set_rate(MAXL + 1);
        out_tready = 1'b1;
        send_one(-5000, 321, 1);
        drain(400);
        nlast = 0;
        foreach (gotd[k]) if (gotd[k].last) nlast++;
        n_tests++;
        if (gotd.size() != 256 || nlast != 1 || !gotd[gotd.size()-1].last) begin
            n_fail++;
            $display("FAIL clamp_count got %0d outputs %0d tlast expected 256 outputs 1 tlast at end",
                     gotd.size(), nlast);
        end
        foreach (gotd[k]) begin
            n_tests++;
            if (gotd[k] !== expd[k]) begin
                n_fail++;
                $display("FAIL clamp[%0d] got i=%0d q=%0d last=%b expected i=%0d q=%0d last=%b v=%b", k,
                         $signed(gotd[k].i), $signed(gotd[k].q), gotd[k].last,
                         $signed(expd[k].i), $signed(expd[k].q), expd[k].last, expd[k].v);
            end
        end
    endtask

    task automatic test_clear();
        reset_logs();
        set_rate(2);
        out_tready = 1'b1;
        send_one(1000, -1000, 0);
        drain(50);
        send_one(2000, 500, 0);
        cycle();
        clear     = 1'b1;
        in_tvalid = 1'b1;
        in_itdata = DW'(9);
        in_qtdata = DW'(9);
        cycle();
        n_tests++;
        if (s_itready !== 1'b0 || s_ihs !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_ready got rdy=%b expected 0", s_itready);
        end
        clear     = 1'b0;
        in_tvalid = 1'b0;
        cycle();
        n_tests++;
        if (s_ovalid !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_drop got out_tvalid=%b expected 0", s_ovalid);
        end
        send_one(300, -300, 1);
        drain(50);
        clear     = 1'b1;
        rate_stb  = 1'b1;
        rate_log2 = '0;
        cycle();
        clear    = 1'b0;
        rate_stb = 1'b0;
        send_one(40, -40, 1);
        drain(50);
        n_tests++;
        if (gotd.size() != 14) begin
            n_fail++;
            $display("FAIL clear_count got %0d expected 14", gotd.size());
        end
        foreach (gotd[k]) begin
            n_tests++;
            if (gotd[k] !== expd[k]) begin
                n_fail++;
                $display("FAIL clear[%0d] got i=%0d q=%0d last=%b expected i=%0d q=%0d last=%b v=%b", k,
                         $signed(gotd[k].i), $signed(gotd[k].q), gotd[k].last,
                         $signed(expd[k].i), $signed(expd[k].q), expd[k].last, expd[k].v);
            end
        end
    endtask

    task automatic test_reset_mid();
        reset_logs();
        set_rate(3);
        out_tready = 1'b1;
        send_one(1234, -4321, 0);
        cycle();
        cycle();
        reset = 1'b0;
        #1;
        n_tests++;
        if (out_tvalid !== 1'b0 || out_tlast !== 1'b0 || out_itdata !== '0 ||
            out_qtdata !== '0 || in_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_outputs got vld=%b last=%b i=%h q=%h rdy=%b expected all 0",
                     out_tvalid, out_tlast, out_itdata, out_qtdata, in_tready);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        n_tests++;
        if (in_tready !== 1'b1 || out_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_release got rdy=%b vld=%b expected rdy=1 vld=0", in_tready, out_tvalid);
        end
        model_flush();
        m_l = DEFL;
        reset_logs();
        send_one(77, 88, 1);
        drain(50);
        n_tests++;
        if (gotd.size() != 4) begin
            n_fail++;
            $display("FAIL rstmid_count got %0d expected 4", gotd.size());
        end
        foreach (gotd[k]) begin
            n_tests++;
            if (gotd[k] !== expd[k]) begin
                n_fail++;
                $display("FAIL rstmid[%0d] got i=%0d q=%0d last=%b expected i=%0d q=%0d last=%b v=%b", k,
                         $signed(gotd[k].i), $signed(gotd[k].q), gotd[k].last,
                         $signed(expd[k].i), $signed(expd[k].q), expd[k].last, expd[k].v);
            end
        end
    endtask

    task automatic test_random();
        int l, sent, n, total;
        for (int rnd = 0; rnd < 4; rnd++) begin
            l = $urandom_range(0, 3);
            n = 15;
            reset_logs();
            set_rate(l);
            sent = 0;
            in_tvalid = 1'b0;
            for (int c = 0; c < 2000 && (sent < n || pend.size() > 0); c++) begin
                if (!in_tvalid && sent < n && $urandom_range(0, 99) < 70) begin
                    in_tvalid = 1'b1;
                    in_itdata = DW'($urandom);
                    in_qtdata = DW'($urandom);
                    in_tlast  = 1'($urandom_range(0, 1));
                end
                out_tready = ($urandom_range(0, 99) < 60);
                cycle();
                if (s_ihs) begin
                    sent++;
                    in_tvalid = 1'b0;
                end
            end
            drain(50);
            total = n << l;
            n_tests++;
            if (gotd.size() != total) begin
                n_fail++;
                $display("FAIL rand%0d_count got %0d expected %0d", rnd, gotd.size(), total);
            end
            foreach (gotd[k]) begin
                n_tests++;
                if (gotd[k] !== expd[k]) begin
                    n_fail++;
                    $display("FAIL rand%0d[%0d] got i=%0d q=%0d last=%b expected i=%0d q=%0d last=%b v=%b",
                             rnd, k, $signed(gotd[k].i), $signed(gotd[k].q), gotd[k].last,
                             $signed(expd[k].i), $signed(expd[k].q), expd[k].last, expd[k].v);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_back_to_back();
        test_clamp();
        test_clear();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/interpolate_iq.md
INTERPOLATE_IQ -- requirements
Module: interpolate_iq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of each I and Q sample, two's complement.
REQ-002 SHALL have parameter MAX_RATE_LOG2, default 8: largest supported log2 interpolation factor.
REQ-003 SHALL have parameter DEFAULT_RATE_LOG2, default 2: log2 factor in effect after reset.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port clear  input  1  synchronous flush, active-high.
REQ-007 SHALL have port rate_stb  input  1  load rate_log2 this cycle.
REQ-008 SHALL have port rate_log2  input  $clog2(MAX_RATE_LOG2+1)  requested log2 factor L; factor R = 2^L.
REQ-009 SHALL have ports in_tvalid/in_tlast  input  1 each, and in_tready  output  1: AXI-stream input handshake.
REQ-010 SHALL have ports in_itdata/in_qtdata  input  DATA_WIDTH each: input I and Q.
REQ-011 SHALL have ports out_tvalid/out_tlast  output  1 each, and out_tready  input  1: AXI-stream output handshake.
REQ-012 SHALL have ports out_itdata/out_qtdata  output  DATA_WIDTH each: interpolated I and Q.

Function
REQ-013 SHALL implement states IDLE (no held sample) and EMIT (emitting R outputs for held sample), with phase counter 0..R-1.
REQ-014 SHALL drive in_tready = 1 in IDLE, and in EMIT only when phase == R-1 and out_tready == 1 (back-to-back accept); 0 otherwise.
REQ-015 SHALL on input accept load the held sample and its tlast, set phase = 0, enter EMIT.
REQ-016 SHALL assert out_tvalid in EMIT only; first output valid the cycle after the accepting handshake (latency 1).
REQ-017 SHALL advance phase by 1 per output handshake; at phase R-1 handshake go to IDLE unless a new input is accepted the same cycle.
REQ-018 SHALL hold out_itdata, out_qtdata, out_tlast stable while out_tvalid && !out_tready.
REQ-019 SHALL assert out_tlast only at phase R-1 of a sample accepted with in_tlast = 1.
REQ-020 SHALL, with R = 1 (L = 0), emit exactly one output per input.
REQ-021 SHALL on rate_stb load active L = min(rate_log2, MAX_RATE_LOG2), force IDLE, phase 0, discard held sample, zero interpolation history; outputs in progress are dropped.
REQ-022 SHALL treat rate_stb and input handshake in the same cycle as rate_stb only (input not accepted; in_tready forced 0 that cycle).
REQ-023 SHALL on clear behave as rate_stb without changing L; clear has priority over rate_stb.

Reset
REQ-024 SHALL while reset is low force: state IDLE, phase 0, L = DEFAULT_RATE_LOG2, history 0, out_tvalid 0, out_tlast 0, out_itdata 0, out_qtdata 0, in_tready 0.
REQ-025 SHALL take effect asynchronously, abandoning any burst mid-emission; first accept possible the first edge after reset deasserts.

Configuration
REQ-026 SHALL support macro INTERPOLATE_IQ_LINEAR_EN.
REQ-027 SHALL without INTERPOLATE_IQ_LINEAR_EN perform zero-order hold: every output of a burst equals the held sample.
REQ-028 SHALL with INTERPOLATE_IQ_LINEAR_EN, per channel, on accept set prev = previous held sample (0 after reset/clear/rate_stb), cur = new sample, and output at phase k = floor((prev*R + k*(cur-prev)) / R) via accumulator of width DATA_WIDTH+1+MAX_RATE_LOG2 (add cur-prev per handshake, arithmetic shift right by L); no overflow or saturation possible.

Verification
REQ-029 SHALL cover ZOH, L=2: one input I=100, Q=-100, tlast=1 -> four outputs 100/-100, out_tlast only on the 4th, then IDLE.
REQ-030 SHALL cover LINEAR_EN, L=2: inputs I=0 then I=400 -> outputs 0,0,0,0 then 0,100,200,300.
REQ-031 SHALL cover LINEAR_EN, L=1, negative floor: inputs I=0 then I=-3 -> second burst 0,-2.
REQ-032 SHALL cover backpressure: out_tready low 3 cycles at phase 1 -> data/phase frozen, in_tready 0, no output lost or duplicated; continuous in_tvalid with out_tready=1 -> out_tvalid never drops.
REQ-033 SHALL cover rate clamp and reset: rate_log2 = MAX_RATE_LOG2+1 -> 256 outputs per input at default MAX; reset low at phase 2 -> all outputs 0 immediately, L = 2 after release.
